// File: rtl/aximm_arb_pkg.sv
// Shared types and AXI constants for the AXI-MM request arbiter.
//   arb_state_e : transaction FSM states
//   AXI_*       : fixed AXI field values used by the NoC wrapper
package aximm_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RSP
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0] AXI_SIZE_64B    = 3'b110;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index for this search
//   gnt     : one-hot grant (zero if no request)
//   gnt_idx : index of the granted requester
//   gnt_any : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDXW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDXW-1:0]    gnt_idx,
  output logic               gnt_any
);

  // Walk from ptr upward with wrap; first hit wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_any && req[j[IDXW-1:0]]) begin
        gnt[j[IDXW-1:0]] = 1'b1;
        gnt_idx          = j[IDXW-1:0];
        gnt_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aximm_req_arbiter.sv
// Shares one single-beat AXI-MM master port between NUM_REQ request/response
// clients with round-robin arbitration; one transaction outstanding.
//   req_*   : client request side (req_ready is a same-cycle grant strobe)
//   rsp_*   : client response side, one-hot rsp_valid to the granted client
//   aximm_* : AXI-MM master (AW/W/B/AR/R), all outputs registered
module aximm_req_arbiter
  import aximm_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXI4_ADDRW     = 64,
  parameter int unsigned AXI4_MAX_DATAW = 512,
  parameter int unsigned AXI4_USERW     = 64,
  parameter int unsigned SRC_NODE       = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*AXI4_ADDRW-1:0]     req_addr,
  input  logic [NUM_REQ*AXI4_MAX_DATAW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [AXI4_MAX_DATAW-1:0]         rsp_data,
  output logic                              rsp_err,
  output logic                              aximm_awvalid,
  input  logic                              aximm_awready,
  output logic [AXI4_ADDRW-1:0]             aximm_awaddr,
  output logic [AXI4_USERW-1:0]             aximm_awuser,
  output logic                              aximm_wvalid,
  input  logic                              aximm_wready,
  output logic [AXI4_MAX_DATAW-1:0]         aximm_wdata,
  output logic                              aximm_wlast,
  output logic [AXI4_USERW-1:0]             aximm_wuser,
  input  logic                              aximm_bvalid,
  output logic                              aximm_bready,
  input  logic [1:0]                        aximm_bresp,
  output logic                              aximm_arvalid,
  input  logic                              aximm_arready,
  output logic [AXI4_ADDRW-1:0]             aximm_araddr,
  output logic [AXI4_USERW-1:0]             aximm_aruser,
  input  logic                              aximm_rvalid,
  output logic                              aximm_rready,
  input  logic [AXI4_MAX_DATAW-1:0]         aximm_rdata,
  input  logic [1:0]                        aximm_rresp
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam logic [AXI4_ADDRW-1:0] SRC_ADDR = AXI4_ADDRW'(SRC_NODE) << (AXI4_ADDRW - 4);

  arb_state_e                state_q, state_d;
  logic [IDXW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]           gnt_idx_q, gnt_idx_d;
  logic [AXI4_ADDRW-1:0]     addr_q, addr_d;
  logic [AXI4_MAX_DATAW-1:0] wdata_q, wdata_d;
  logic [AXI4_MAX_DATAW-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;

  logic [NUM_REQ-1:0]        gnt_oh_c;
  logic [IDXW-1:0]           gnt_idx_c;
  logic                      gnt_any_c;

  logic [AXI4_ADDRW-1:0]     addr_arr [NUM_REQ];
  logic [AXI4_MAX_DATAW-1:0] wdata_arr[NUM_REQ];

  // Unpack the flat request buses per client.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AXI4_ADDRW +: AXI4_ADDRW];
    assign wdata_arr[i] = req_wdata[i*AXI4_MAX_DATAW +: AXI4_MAX_DATAW];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_oh_c),
    .gnt_idx (gnt_idx_c),
    .gnt_any (gnt_any_c)
  );

  // Next-state, payload capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Grant suppressed while rst is asserted so reset really zeroes every output.
        if (gnt_any_c && !rst) begin
          req_ready = gnt_oh_c;
          gnt_idx_d = gnt_idx_c;
          addr_d    = addr_arr[gnt_idx_c];
          wdata_d   = wdata_arr[gnt_idx_c];
          rr_ptr_d  = (gnt_idx_c == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDXW'(1);
          state_d   = req_write[gnt_idx_c] ? ST_AW : ST_AR;
        end
      end
      ST_AW: if (awvalid_q && aximm_awready) state_d = ST_W;
      ST_W:  if (wvalid_q && aximm_wready)   state_d = ST_B;
      ST_B: begin
        if (bready_q && aximm_bvalid) begin
          rsp_data_d = '0;
          rsp_err_d  = (aximm_bresp != AXI_RESP_OKAY);
          state_d    = ST_RSP;
        end
      end
      ST_AR: if (arvalid_q && aximm_arready) state_d = ST_R;
      ST_R: begin
        if (rready_q && aximm_rvalid) begin
          rsp_data_d = aximm_rdata;
          rsp_err_d  = (aximm_rresp != AXI_RESP_OKAY);
          state_d    = ST_RSP;
        end
      end
      ST_RSP: if (rsp_valid_q[gnt_idx_q] && rsp_ready[gnt_idx_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are flops decoded from the upcoming state.
    awvalid_d   = (state_d == ST_AW);
    wvalid_d    = (state_d == ST_W);
    bready_d    = (state_d == ST_B);
    arvalid_d   = (state_d == ST_AR);
    rready_d    = (state_d == ST_R);
    rsp_valid_d = (state_d == ST_RSP) ? (NUM_REQ'(1) << gnt_idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign aximm_awvalid = awvalid_q;
  assign aximm_awaddr  = addr_q;
  assign aximm_awuser  = AXI4_USERW'(SRC_ADDR);
  assign aximm_wvalid  = wvalid_q;
  assign aximm_wdata   = wdata_q;
  assign aximm_wlast   = wvalid_q;
  assign aximm_wuser   = AXI4_USERW'(SRC_ADDR);
  assign aximm_bready  = bready_q;
  assign aximm_arvalid = arvalid_q;
  assign aximm_araddr  = addr_q;
  assign aximm_aruser  = AXI4_USERW'(SRC_ADDR);
  assign aximm_rready  = rready_q;

endmodule

// File: tb/tb_aximm_req_arbiter.sv
// Directed self-checking bench for aximm_req_arbiter.
module tb_aximm_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned UW = 64;
  localparam logic [AW-1:0] SRC_ADDR_EXP = 64'd0 << 60;

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [AW-1:0]   awaddr, araddr;
  logic [UW-1:0]   awuser, wuser, aruser;
  logic [DW-1:0]   wdata, rdata;
  logic [1:0]      bresp, rresp;

  int checks = 0;
  int errors = 0;

  aximm_req_arbiter #(
    .NUM_REQ(N), .AXI4_ADDRW(AW), .AXI4_MAX_DATAW(DW), .AXI4_USERW(UW), .SRC_NODE(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .aximm_awvalid(awvalid), .aximm_awready(awready), .aximm_awaddr(awaddr), .aximm_awuser(awuser),
    .aximm_wvalid(wvalid), .aximm_wready(wready), .aximm_wdata(wdata), .aximm_wlast(wlast),
    .aximm_wuser(wuser),
    .aximm_bvalid(bvalid), .aximm_bready(bready), .aximm_bresp(bresp),
    .aximm_arvalid(arvalid), .aximm_arready(arready), .aximm_araddr(araddr), .aximm_aruser(aruser),
    .aximm_rvalid(rvalid), .aximm_rready(rready), .aximm_rdata(rdata), .aximm_rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Poll (bounded) for a response, check it, then let the handshake edge pass.
  task automatic wait_rsp(input logic [N-1:0] exp_v, input logic [DW-1:0] exp_d, input logic exp_e);
    int n = 0;
    while (rsp_valid == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid", rsp_valid === exp_v);
    chk("rsp_data", rsp_data === exp_d);
    chk("rsp_err", rsp_err === exp_e);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '1;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b1; rvalid = 1'b1; bresp = 2'b00; rresp = 2'b00; rdata = '0;
    repeat (3) tick();
    chk("reset_awvalid", awvalid === 1'b0);
    chk("reset_rsp_valid", rsp_valid === 4'b0000);
    chk("reset_req_ready", req_ready === 4'b0000);
    rst = 1'b0;

    // Reset in the middle of a write (awvalid held by awready=0).
    awready = 1'b0;
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[1*AW +: AW] = 64'h1111;
    #1;
    chk("t1_grant1", req_ready === 4'b0010);
    tick();
    req_valid = '0;
    chk("t1_awvalid", awvalid === 1'b1);
    chk("t1_awaddr", awaddr === 64'h1111);
    rst = 1'b1;
    tick();
    chk("t1_rst_awvalid", awvalid === 1'b0);
    chk("t1_rst_awaddr", awaddr === 64'h0);
    chk("t1_rst_wvalid", wvalid === 1'b0);
    chk("t1_rst_bready", bready === 1'b0);
    chk("t1_rst_rsp", rsp_valid === 4'b0000);
    chk("t1_rst_req_ready", req_ready === 4'b0000);
    tick(); tick();
    rst = 1'b0;
    awready = 1'b1;
    req_valid = 4'b1001; req_write = 4'b1001;
    req_addr[0*AW +: AW] = 64'hA0;
    req_addr[3*AW +: AW] = 64'hA3;
    #1;
    chk("t1_ptr0_grant", req_ready === 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_awaddr0", awaddr === 64'hA0);
    wait_rsp(4'b0001, '0, 1'b0);

    // Req 2 write then read, exact cycle latency (ptr now 1).
    req_valid = 4'b0100; req_write = 4'b0100;
    req_addr[2*AW +: AW] = 64'h2000_0000_0000_0003;
    req_wdata[2*DW +: DW] = 512'hDEADBEEF;
    #1;
    chk("t2_grant", req_ready === 4'b0100);
    tick();
    req_valid = '0;
    chk("t2_awvalid", awvalid === 1'b1);
    chk("t2_awaddr", awaddr === 64'h2000_0000_0000_0003);
    chk("t2_awuser", awuser === SRC_ADDR_EXP);
    chk("t2_wvalid_early", wvalid === 1'b0);
    tick();
    chk("t2_wvalid", wvalid === 1'b1);
    chk("t2_wdata", wdata === 512'hDEADBEEF);
    chk("t2_wlast", wlast === 1'b1);
    chk("t2_wuser", wuser === SRC_ADDR_EXP);
    chk("t2_aw_dropped", awvalid === 1'b0);
    tick();
    chk("t2_bready", bready === 1'b1);
    tick();
    chk("t2_rsp_valid", rsp_valid === 4'b0100);
    chk("t2_rsp_data", rsp_data === 512'h0);
    chk("t2_rsp_err", rsp_err === 1'b0);
    tick();
    chk("t2_rsp_done", rsp_valid === 4'b0000);
    rdata = 512'hDEADBEEF;
    req_valid = 4'b0100; req_write = 4'b0000;
    #1;
    chk("t2_rd_grant", req_ready === 4'b0100);
    tick();
    req_valid = '0;
    chk("t2_arvalid", arvalid === 1'b1);
    chk("t2_araddr", araddr === 64'h2000_0000_0000_0003);
    chk("t2_aruser", aruser === SRC_ADDR_EXP);
    chk("t2_rd_no_aw", awvalid === 1'b0);
    tick();
    chk("t2_rready", rready === 1'b1);
    tick();
    chk("t2_rd_rsp_valid", rsp_valid === 4'b0100);
    chk("t2_rd_rsp_data", rsp_data === 512'hDEADBEEF);
    chk("t2_rd_rsp_err", rsp_err === 1'b0);
    tick();

    // Reset pointer, then all four held: grants 0,1,2,3,0,1,2,3.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 4'b1111; req_write = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      #1;
      n = 0;
      while (req_ready == '0 && n < 10) begin
        tick();
        n++;
      end
      chk("t3_grant_order", req_ready === (4'(1) << (k % 4)));
      chk("t3_onehot", $onehot(req_ready) === 1'b1);
      tick();
    end
    req_valid = '0;
    wait_rsp(4'b1000, 512'hDEADBEEF, 1'b0);

    // Backpressure on AW (5 cycles) then W (3 cycles); ptr now 0.
    awready = 1'b0; wready = 1'b0;
    req_valid = 4'b0010; req_write = 4'b0010;
    req_addr[1*AW +: AW] = 64'h55;
    req_wdata[1*DW +: DW] = 512'h77;
    #1;
    chk("t4_grant", req_ready === 4'b0010);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_awvalid_hold", awvalid === 1'b1);
      chk("t4_awaddr_hold", awaddr === 64'h55);
      chk("t4_no_wvalid", wvalid === 1'b0);
      tick();
    end
    awready = 1'b1;
    chk("t4_awvalid_last", awvalid === 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4_wvalid_hold", wvalid === 1'b1);
      chk("t4_wdata_hold", wdata === 512'h77);
      tick();
    end
    wready = 1'b1;
    wait_rsp(4'b0010, '0, 1'b0);

    // Error responses: write by req 2, read by req 3.
    bresp = 2'b10;
    req_valid = 4'b0100; req_write = 4'b0100;
    #1;
    chk("t5_wr_grant", req_ready === 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp(4'b0100, '0, 1'b1);
    bresp = 2'b00;
    rresp = 2'b11; rdata = 512'h1234;
    req_valid = 4'b1000; req_write = 4'b0000;
    #1;
    chk("t5_rd_grant", req_ready === 4'b1000);
    tick();
    req_valid = '0;
    wait_rsp(4'b1000, 512'h1234, 1'b1);
    rresp = 2'b00;

    // rsp_ready held low 4 cycles with req 1 waiting.
    rsp_ready = '0;
    req_valid = 4'b0001; req_write = 4'b0001;
    #1;
    chk("t6_grant0", req_ready === 4'b0001);
    tick();
    req_valid = 4'b0010; req_write = 4'b0000;
    n = 0;
    while (rsp_valid == '0 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("t6_rsp_hold", rsp_valid === 4'b0001);
      chk("t6_no_grant", req_ready === 4'b0000);
      tick();
    end
    rsp_ready = 4'b0001;
    #1;
    chk("t6_rsp_final", rsp_valid === 4'b0001);
    chk("t6_no_grant_hs", req_ready === 4'b0000);
    tick();
    chk("t6_rsp_cleared", rsp_valid === 4'b0000);
    chk("t6_next_grant", req_ready === 4'b0010);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    wait_rsp(4'b0010, 512'h1234, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
